line_mem_responder: RTL and testbench

LINE_MEM_RESPONDER -- requirements
Module: line_mem_responder

---
 rtl/line_mem_responder_pkg.sv | 26 ++
 rtl/line_mem_responder_if.sv | 33 +++
 rtl/line_mem_responder_array.sv | 22 ++
 rtl/line_mem_responder.sv | 143 ++++++++++++++
 tb/tb_line_mem_responder.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/line_mem_responder_pkg.sv
// Shared types and geometry for the line-burst memory responder.
// CACHE_B (log2 of line size in bytes) defaults to 4 unless defined by the build.
`ifndef CACHE_B
`define CACHE_B 4
`endif

package line_mem_pkg;

  localparam int unsigned CACHE_B            = `CACHE_B;
  localparam int unsigned WORDS_PER_LINE_DEF = 2 ** (CACHE_B - 2);

  // Index width for a count of n items, never narrower than one bit
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int unsigned BEAT_W = idx_w(WORDS_PER_LINE_DEF);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_RBURST = 2'd2,
    S_WBURST = 2'd3
  } state_e;

endpackage

// File: rtl/line_mem_responder_if.sv
// Cache <-> responder line-burst bus. err exists only with LINE_MEM_RESPONDER_ERR_EN.
interface line_mem_responder_if;

  logic        req_valid;
  logic        req_write;
  logic [31:0] req_addr;
  logic        req_ready;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        beat;
  logic [31:0] count;
  logic        done;
`ifdef LINE_MEM_RESPONDER_ERR_EN
  logic        err;
`endif

  modport master (
    output req_valid, req_write, req_addr, wdata,
    input  req_ready, rdata, beat, count, done
`ifdef LINE_MEM_RESPONDER_ERR_EN
    , input err
`endif
  );

  modport slave (
    input  req_valid, req_write, req_addr, wdata,
    output req_ready, rdata, beat, count, done
`ifdef LINE_MEM_RESPONDER_ERR_EN
    , output err
`endif
  );

endinterface

// File: rtl/line_mem_responder_array.sv
// Single-port word store: synchronous write, asynchronous read, never reset.
module line_mem_array #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned AW    = 10
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] addr_i,
  input  logic [31:0]   wdata_i,
  output logic [31:0]   rdata_o
);

  logic [31:0] mem [DEPTH];

  // Write port
  always_ff @(posedge clk_i) begin
    if (we_i) mem[addr_i] <= wdata_i;
  end

  assign rdata_o = mem[addr_i];

endmodule

// File: rtl/line_mem_responder.sv
// Line-burst memory responder: accepts a line fetch/write-back, waits LATENCY
// cycles, then streams WORDS_PER_LINE beats with no stalls.
// Optional macro LINE_MEM_RESPONDER_ERR_EN: out-of-range lines pulse err instead.
module line_mem_responder
  import line_mem_pkg::*;
#(
  parameter int unsigned WORDS_PER_LINE = WORDS_PER_LINE_DEF,
  parameter int unsigned DEPTH_WORDS    = 1024,
  parameter int unsigned LATENCY        = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  line_mem_responder_if.slave  bus
);

  localparam int unsigned CNT_W = (WORDS_PER_LINE == WORDS_PER_LINE_DEF) ? BEAT_W
                                                                          : idx_w(WORDS_PER_LINE);
  localparam int unsigned LAT_W = idx_w(LATENCY + 1);
  localparam int unsigned AW    = idx_w(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(WORDS_PER_LINE - 1);
  localparam logic [LAT_W-1:0] LAT_LOAD  = (LATENCY > 0) ? LAT_W'(LATENCY - 1) : '0;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [LAT_W-1:0]  lat_q, lat_d;
  logic [31:0]       base_q, base_d;
  logic              wr_q, wr_d;
  logic [31:0]       req_base;
  logic              line_oob;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [31:0]       mem_rdata;
  logic              unused_addr_lsbs;

  // Word index of the line base: byte offset within the line is discarded
  assign req_base         = 32'(bus.req_addr[31:CACHE_B]) << (CACHE_B - 2);
  assign unused_addr_lsbs = ^bus.req_addr[CACHE_B-1:0];
  assign mem_addr         = AW'((base_q + 32'(cnt_q)) % DEPTH_WORDS);

`ifdef LINE_MEM_RESPONDER_ERR_EN
  logic err_q, err_d;
  assign line_oob = (req_base >= DEPTH_WORDS) ||
                    ((DEPTH_WORDS - req_base) < WORDS_PER_LINE);
  assign bus.err  = err_q;
`else
  assign line_oob = 1'b0;
`endif

  // State and datapath registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      lat_q   <= '0;
      base_q  <= '0;
      wr_q    <= 1'b0;
`ifdef LINE_MEM_RESPONDER_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lat_q   <= lat_d;
      base_q  <= base_d;
      wr_q    <= wr_d;
`ifdef LINE_MEM_RESPONDER_ERR_EN
      err_q   <= err_d;
`endif
    end
  end

  // Next-state: request capture, latency countdown, beat counting
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    base_d  = base_q;
    wr_d    = wr_q;
`ifdef LINE_MEM_RESPONDER_ERR_EN
    err_d   = (state_q == S_IDLE) && bus.req_valid && line_oob;
`endif
    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (bus.req_valid && !line_oob) begin
          base_d  = req_base;
          wr_d    = bus.req_write;
          lat_d   = LAT_LOAD;
          state_d = (LATENCY > 0) ? S_WAIT : (bus.req_write ? S_WBURST : S_RBURST);
        end
      end
      S_WAIT: begin
        if (lat_q == '0) state_d = wr_q ? S_WBURST : S_RBURST;
        else             lat_d   = lat_q - LAT_W'(1);
      end
      S_RBURST, S_WBURST: begin
        if (cnt_q == LAST_BEAT) begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state
  always_comb begin
    bus.req_ready = 1'b0;
    bus.beat      = 1'b0;
    bus.done      = 1'b0;
    bus.rdata     = '0;
    bus.count     = 32'(cnt_q);
    mem_we        = 1'b0;
    unique case (state_q)
      S_IDLE:   bus.req_ready = 1'b1;
      S_RBURST: begin
        bus.beat  = 1'b1;
        bus.done  = (cnt_q == LAST_BEAT);
        bus.rdata = mem_rdata;
      end
      S_WBURST: begin
        bus.beat  = 1'b1;
        bus.done  = (cnt_q == LAST_BEAT);
        mem_we    = 1'b1;
      end
      default: ;
    endcase
  end

  line_mem_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_mem (
    .clk_i   (clk),
    .we_i    (mem_we),
    .addr_i  (mem_addr),
    .wdata_i (bus.wdata),
    .rdata_o (mem_rdata)
  );

endmodule

// File: tb/tb_line_mem_responder.sv
// Directed bench: cycle table on a LATENCY=2 instance plus hand sequences for
// reset mid-burst, zero latency and address wrap / error on a 14-word instance.
module tb_line_mem_responder;

  typedef struct {
    logic        v;
    logic        w;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] rdy;
    logic [31:0] b;
    logic [31:0] cnt;
    logic [31:0] dn;
    logic [31:0] rd;
  } vec_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  vec_t tbl[$];

  line_mem_responder_if if0 ();
  line_mem_responder_if if1 ();

  line_mem_responder #(.WORDS_PER_LINE(4), .DEPTH_WORDS(1024), .LATENCY(2)) u_dut0 (
    .clk(clk), .reset(reset), .bus(if0));
  line_mem_responder #(.WORDS_PER_LINE(4), .DEPTH_WORDS(14), .LATENCY(0)) u_dut1 (
    .clk(clk), .reset(reset), .bus(if1));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required $finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic drive(input int d, input logic v, input logic w,
                       input logic [31:0] a, input logic [31:0] wd);
    if (d == 0) begin
      if0.req_valid = v; if0.req_write = w; if0.req_addr = a; if0.wdata = wd;
    end else begin
      if1.req_valid = v; if1.req_write = w; if1.req_addr = a; if1.wdata = wd;
    end
  endtask

  task automatic sample(input int d, output logic [31:0] rdy, output logic [31:0] b,
                        output logic [31:0] cnt, output logic [31:0] dn,
                        output logic [31:0] rd);
    if (d == 0) begin
      rdy = 32'(if0.req_ready); b = 32'(if0.beat); cnt = if0.count;
      dn  = 32'(if0.done);      rd = if0.rdata;
    end else begin
      rdy = 32'(if1.req_ready); b = 32'(if1.beat); cnt = if1.count;
      dn  = 32'(if1.done);      rd = if1.rdata;
    end
  endtask

  task automatic chk_idle(input int d, input string nm);
    logic [31:0] rdy, b, cnt, dn, rd;
    sample(d, rdy, b, cnt, dn, rd);
    chk($sformatf("d%0d %s ready", d, nm), rdy, 1);
    chk($sformatf("d%0d %s beat", d, nm), b, 0);
    chk($sformatf("d%0d %s count", d, nm), cnt, 0);
    chk($sformatf("d%0d %s done", d, nm), dn, 0);
    chk($sformatf("d%0d %s rdata", d, nm), rd, 0);
  endtask

  function automatic logic [3:0][31:0] mk4(input logic [31:0] a, input logic [31:0] b,
                                           input logic [31:0] c, input logic [31:0] e);
    logic [3:0][31:0] r;
    r[0] = a; r[1] = b; r[2] = c; r[3] = e;
    return r;
  endfunction

  function automatic void add(input logic v, input logic w, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rdy,
                              input logic [31:0] b, input logic [31:0] cnt,
                              input logic [31:0] dn, input logic [31:0] rd);
    tbl.push_back('{v, w, a, wd, rdy, b, cnt, dn, rd});
  endfunction

  // One full request: accept, fixed wait, four beats, back to idle
  task automatic burst(input int d, input logic wr, input logic [31:0] addr,
                       input logic [3:0][31:0] wd, input logic [3:0][31:0] exp,
                       input string nm);
    logic [31:0] rdy, b, cnt, dn, rd;
    int lat;
    lat = (d == 0) ? 2 : 0;
    @(negedge clk);
    drive(d, 1'b1, wr, addr, 32'h0);
    #1 sample(d, rdy, b, cnt, dn, rd);
    chk($sformatf("d%0d %s accept ready", d, nm), rdy, 1);
    @(negedge clk);
    drive(d, 1'b0, 1'b0, 32'h0, 32'h0);
    for (int k = 0; k < lat; k++) begin
      #1 sample(d, rdy, b, cnt, dn, rd);
      chk($sformatf("d%0d %s wait%0d beat", d, nm, k), b, 0);
      chk($sformatf("d%0d %s wait%0d ready", d, nm, k), rdy, 0);
      @(negedge clk);
    end
    for (int i = 0; i < 4; i++) begin
      drive(d, 1'b0, 1'b0, 32'h0, wd[i]);
      #1 sample(d, rdy, b, cnt, dn, rd);
      chk($sformatf("d%0d %s beat%0d beat", d, nm, i), b, 1);
      chk($sformatf("d%0d %s beat%0d count", d, nm, i), cnt, 32'(i));
      chk($sformatf("d%0d %s beat%0d done", d, nm, i), dn, 32'(i == 3));
      chk($sformatf("d%0d %s beat%0d rdata", d, nm, i), rd, wr ? 32'h0 : exp[i]);
      @(negedge clk);
    end
    #1 chk_idle(d, {nm, " end"});
  endtask

  initial begin
    logic [31:0] rdy, b, cnt, dn, rd;
    logic [3:0][31:0] z;
    z = '0;

    // Cycle table for the LATENCY=2 instance
    add(1'b1, 1'b1, 32'h40, 32'h0, 1, 0, 0, 0, 0);
    add(1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    add(1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      add(1'b0, 1'b0, 32'h0, 32'hA0 + 32'(i), 0, 1, 32'(i), 32'(i == 3), 0);
    add(1'b1, 1'b0, 32'h40, 32'h0, 1, 0, 0, 0, 0);
    add(1'b1, 1'b1, 32'h80, 32'hDEAD, 0, 0, 0, 0, 0);
    add(1'b1, 1'b1, 32'h80, 32'hDEAD, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      add(1'b1, 1'b1, 32'h80, 32'hDEAD, 0, 1, 32'(i), 32'(i == 3), 32'hA0 + 32'(i));
    add(1'b1, 1'b1, 32'h80, 32'h0, 1, 0, 0, 0, 0);
    add(1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    add(1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      add(1'b0, 1'b0, 32'h0, 32'h11 * 32'(i + 1), 0, 1, 32'(i), 32'(i == 3), 0);
    add(1'b1, 1'b0, 32'h8C, 32'h0, 1, 0, 0, 0, 0);
    add(1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    add(1'b0, 1'b0, 32'h0, 32'h0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++)
      add(1'b0, 1'b0, 32'h0, 32'h0, 0, 1, 32'(i), 32'(i == 3), 32'h11 * 32'(i + 1));
    add(1'b0, 1'b0, 32'h0, 32'h0, 1, 0, 0, 0, 0);

    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    #1 chk_idle(0, "in reset");
    chk_idle(1, "in reset");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    #1 chk_idle(0, "after reset");
    chk_idle(1, "after reset");

    foreach (tbl[r]) begin
      @(negedge clk);
      drive(0, tbl[r].v, tbl[r].w, tbl[r].a, tbl[r].wd);
      #1 sample(0, rdy, b, cnt, dn, rd);
      chk($sformatf("row%0d ready", r), rdy, tbl[r].rdy);
      chk($sformatf("row%0d beat", r), b, tbl[r].b);
      chk($sformatf("row%0d count", r), cnt, tbl[r].cnt);
      chk($sformatf("row%0d done", r), dn, tbl[r].dn);
      chk($sformatf("row%0d rdata", r), rd, tbl[r].rd);
    end

    // Reset during the second write-back beat: only word 0 is updated
    burst(0, 1'b1, 32'hC0, mk4(32'h51, 32'h52, 32'h53, 32'h54), z, "preC0");
    @(negedge clk);
    drive(0, 1'b1, 1'b1, 32'hC0, 32'h0);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h61);
    #1 sample(0, rdy, b, cnt, dn, rd);
    chk("rst beat0 beat", b, 1);
    @(negedge clk);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h62);
    #1 sample(0, rdy, b, cnt, dn, rd);
    chk("rst beat1 count", cnt, 1);
    reset = 1'b0;
    #1 chk_idle(0, "rst mid-burst");
    @(negedge clk);
    reset = 1'b1;
    #1 chk_idle(0, "rst released");
    burst(0, 1'b0, 32'hC0, z, mk4(32'h61, 32'h52, 32'h53, 32'h54), "fetchC0");

    // Zero-latency instance, 14-word store
    burst(1, 1'b1, 32'h00, mk4(32'hB0, 32'hB1, 32'hB2, 32'hB3), z, "wr00");
    burst(1, 1'b0, 32'h00, z, mk4(32'hB0, 32'hB1, 32'hB2, 32'hB3), "rd00");
`ifdef LINE_MEM_RESPONDER_ERR_EN
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 32'h30, 32'hC0);
    #1 sample(1, rdy, b, cnt, dn, rd);
    chk("err accept ready", rdy, 1);
    @(negedge clk);
    drive(1, 1'b0, 1'b0, 32'h0, 32'hC1);
    #1 sample(1, rdy, b, cnt, dn, rd);
    chk("err pulse", 32'(if1.err), 1);
    chk("err no beat", b, 0);
    @(negedge clk);
    #1 sample(1, rdy, b, cnt, dn, rd);
    chk("err cleared", 32'(if1.err), 0);
    chk("err idle beat", b, 0);
    chk("err idle ready", rdy, 1);
    burst(1, 1'b0, 32'h00, z, mk4(32'hB0, 32'hB1, 32'hB2, 32'hB3), "rd00 kept");
`else
    burst(1, 1'b1, 32'h30, mk4(32'hC0, 32'hC1, 32'hC2, 32'hC3), z, "wr30 wrap");
    burst(1, 1'b0, 32'h00, z, mk4(32'hC2, 32'hC3, 32'hB2, 32'hB3), "rd00 wrapped");
    burst(1, 1'b0, 32'h30, z, mk4(32'hC0, 32'hC1, 32'hC2, 32'hC3), "rd30 wrap");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
